// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel FIFO bank.
// NUM_VC independent circular buffers share one storage array. Each VC has
// its own write/read pointer pair with an extra wrap bit, so full and empty
// are exact. Reads are first-word fall-through: data_out always shows the
// head flit of VC rd_vc.
// Optional feature: define VC_FIFO_ERR_EN to add the sticky 'err' output,
// which sets after any rejected request to an existing VC (write to a full
// VC or read of an empty VC).
module vc_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int NUM_VC   = 4,
    parameter int AFULL_TH = DEPTH - 2,
    parameter int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int PTR_W    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [VC_W-1:0]          wr_vc,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     read,
    input  logic [VC_W-1:0]          rd_vc,
    output logic [WIDTH-1:0]         data_out,
    output logic [NUM_VC-1:0]        full,
    output logic [NUM_VC-1:0]        empty,
    output logic [NUM_VC-1:0]        afull,
`ifdef VC_FIFO_ERR_EN
    output logic                     err,
`endif
    output logic [NUM_VC*PTR_W-1:0]  count
);

    localparam int AW = PTR_W - 1;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

    logic [WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_VC];
    logic [PTR_W-1:0] rd_ptr [NUM_VC];

    logic wr_vc_ok;
    logic rd_vc_ok;
    logic wr_ok;
    logic rd_ok;

    // Per-VC status flags and occupancy, all derived from registered pointers.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves a bit unassigned and no latch is inferred.
        full  = '0;
        empty = '0;
        afull = '0;
        count = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            logic [PTR_W-1:0] occ;
            occ = wr_ptr[v] - rd_ptr[v];
            full[v]  = (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]) &&
                       (wr_ptr[v][AW] != rd_ptr[v][AW]);
            empty[v] = (wr_ptr[v] == rd_ptr[v]);
            afull[v] = (occ >= AFULL_LVL);
            count[v*PTR_W +: PTR_W] = occ;
        end
    end

    // Request qualification: range check, then full/empty of the target VC.
    // A same-cycle read never makes room for a write and a same-cycle write
    // never feeds a read, because both look only at current pointers.
    always_comb begin
        wr_vc_ok = (int'(wr_vc) < NUM_VC);
        rd_vc_ok = (int'(rd_vc) < NUM_VC);
        wr_ok    = write && wr_vc_ok && !full[wr_vc];
        rd_ok    = read && rd_vc_ok && !empty[rd_vc];
    end

    // Head flit of the selected VC; meaningless while that VC is empty.
    always_comb begin
        data_out = mem[rd_vc][rd_ptr[rd_vc][AW-1:0]];
    end

    // Storage write for accepted flits.
    // NOTE: the data array is deliberately left out of reset; the pointers
    // alone define which entries are valid, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_vc][wr_ptr[wr_vc][AW-1:0]] <= data_in;
        end
    end

    // Pointer advance per VC; the wrap bit toggles naturally on overflow of
    // the low bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                // NOTE: sequential state uses non-blocking assignment so every
                // register samples pre-edge values regardless of block order.
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_ok && (wr_vc == VC_W'(v))) begin
                    wr_ptr[v] <= wr_ptr[v] + 1'b1;
                end
                if (rd_ok && (rd_vc == VC_W'(v))) begin
                    rd_ptr[v] <= rd_ptr[v] + 1'b1;
                end
            end
        end
    end

`ifdef VC_FIFO_ERR_EN
    logic rejected;

    // A request to an existing VC that is turned away by full/empty.
    always_comb begin
        rejected = (write && wr_vc_ok && full[wr_vc]) ||
                   (read && rd_vc_ok && empty[rd_vc]);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (rejected) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed bench for vc_fifo with default parameters
// (WIDTH=16, DEPTH=16, NUM_VC=4, AFULL_TH=14). Inputs change 1 ns after the
// rising edge and outputs are sampled there as well.
module tb_vc_fifo;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 16;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int PW     = 5;

    logic                    clk;
    logic                    reset;
    logic                    write;
    logic [VC_W-1:0]         wr_vc;
    logic [WIDTH-1:0]        data_in;
    logic                    read;
    logic [VC_W-1:0]         rd_vc;
    logic [WIDTH-1:0]        data_out;
    logic [NUM_VC-1:0]       full;
    logic [NUM_VC-1:0]       empty;
    logic [NUM_VC-1:0]       afull;
    logic [NUM_VC*PW-1:0]    count;
`ifdef VC_FIFO_ERR_EN
    logic                    err;
`endif

    int checks = 0;
    int errors = 0;

    vc_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .wr_vc    (wr_vc),
        .data_in  (data_in),
        .read     (read),
        .rd_vc    (rd_vc),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
`ifdef VC_FIFO_ERR_EN
        .err      (err),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] cnt(input int v);
        return count[v*PW +: PW];
    endfunction

    // One clock cycle with the given request inputs, then back to idle.
    task automatic cycle(input logic wr, input int wvc, input logic [WIDTH-1:0] din,
                         input logic rd, input int rvc);
        write   = wr;
        wr_vc   = VC_W'(wvc);
        data_in = din;
        read    = rd;
        rd_vc   = VC_W'(rvc);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        wr_vc   = '0;
        rd_vc   = '0;
        data_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 64'(empty), 64'hF);
        check("rst_full",  64'(full),  64'h0);
        check("rst_afull", 64'(afull), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill VC2 with 0..15; afull from the 14th write, full after 16th
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 2, WIDTH'(k - 1), 1'b0, 2);
            check("fill_cnt2",  64'(cnt(2)), 64'(k));
            check("fill_afull", 64'(afull),  (k >= 14) ? 64'h4 : 64'h0);
        end
        check("fill_full",  64'(full),  64'h4);
        check("fill_empty", 64'(empty), 64'hB);
        cycle(1'b1, 2, 16'hBEEF, 1'b0, 2);
        check("ovf_cnt2", 64'(cnt(2)), 64'd16);
        check("ovf_full", 64'(full),   64'h4);

        // Drain VC2 in order
        rd_vc = 2'd2;
        for (int i = 0; i < 16; i++) begin
            #0;
            check("drain_data", 64'(data_out), 64'(i));
            cycle(1'b0, 0, '0, 1'b1, 2);
        end
        check("drain_empty", 64'(empty), 64'hF);
        check("drain_cnt2",  64'(cnt(2)), 64'd0);
        cycle(1'b0, 0, '0, 1'b1, 2);
        check("udf_cnt2",  64'(cnt(2)), 64'd0);
        check("udf_empty", 64'(empty),  64'hF);

        // Pointers have wrapped: one more flit still goes through
        cycle(1'b1, 2, 16'h1234, 1'b0, 2);
        check("wrap_cnt2", 64'(cnt(2)),   64'd1);
        check("wrap_data", 64'(data_out), 64'h1234);
        cycle(1'b0, 0, '0, 1'b1, 2);
        check("wrap_empty", 64'(empty), 64'hF);

        // VC0 with 3 entries, simultaneous write+read keeps count
        cycle(1'b1, 0, 16'h0101, 1'b0, 0);
        cycle(1'b1, 0, 16'h0202, 1'b0, 0);
        cycle(1'b1, 0, 16'h0303, 1'b0, 0);
        check("vc0_head", 64'(data_out), 64'h0101);
        check("vc0_cnt",  64'(cnt(0)),   64'd3);
        cycle(1'b1, 0, 16'hAAAA, 1'b1, 0);
        check("rw_cnt0",  64'(cnt(0)),   64'd3);
        check("rw_data",  64'(data_out), 64'h0202);
        cycle(1'b0, 0, '0, 1'b1, 0);
        check("rw_data2", 64'(data_out), 64'h0303);
        cycle(1'b0, 0, '0, 1'b1, 0);
        check("rw_data3", 64'(data_out), 64'hAAAA);
        cycle(1'b0, 0, '0, 1'b1, 0);
        check("rw_empty", 64'(empty), 64'hF);

        // Write+read of empty VC1: no bypass, read rejected
        cycle(1'b1, 1, 16'h5555, 1'b1, 1);
        check("nobyp_cnt1", 64'(cnt(1)),   64'd1);
        check("nobyp_data", 64'(data_out), 64'h5555);

        // Accepted read and write on different VCs
        cycle(1'b1, 3, 16'h3333, 1'b1, 1);
        check("diff_cnt1",  64'(cnt(1)), 64'd0);
        check("diff_cnt3",  64'(cnt(3)), 64'd1);
        check("diff_empty", 64'(empty),  64'h7);

        // Bring VC3 to 5 entries, then asynchronous reset mid-cycle
        for (int k = 0; k < 4; k++) cycle(1'b1, 3, WIDTH'(16'h3000 + k), 1'b0, 3);
        check("pre_rst_cnt3", 64'(cnt(3)), 64'd5);
        #3;
        reset = 1'b0;
        #1;
        check("arst_empty", 64'(empty), 64'hF);
        check("arst_count", 64'(count), 64'h0);
        check("arst_full",  64'(full),  64'h0);
`ifdef VC_FIFO_ERR_EN
        check("arst_err", 64'(err), 64'h0);
`endif
        // Requests while held in reset are ignored
        write   = 1'b1;
        wr_vc   = 2'd3;
        data_in = 16'hDEAD;
        @(posedge clk);
        #1;
        write = 1'b0;
        check("inrst_count", 64'(count), 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Normal operation after reset
        cycle(1'b1, 3, 16'h0F0F, 1'b0, 3);
        check("post_cnt3", 64'(cnt(3)),   64'd1);
        check("post_data", 64'(data_out), 64'h0F0F);

`ifdef VC_FIFO_ERR_EN
        check("err_clear", 64'(err), 64'h0);
        for (int k = 0; k < 16; k++) cycle(1'b1, 0, WIDTH'(k), 1'b0, 3);
        check("err_nofull", 64'(err), 64'h0);
        cycle(1'b1, 0, 16'hFFFF, 1'b0, 3);
        check("err_set", 64'(err), 64'h1);
        repeat (3) cycle(1'b0, 0, '0, 1'b0, 3);
        check("err_hold", 64'(err), 64'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter WIDTH, default 16: bits per flit.
REQ-002 Parameter DEPTH, default 16: entries per virtual channel (VC); power of two, >=2.
REQ-003 Parameter NUM_VC, default 4: number of independent VCs; >=1.
REQ-004 Parameter AFULL_TH, default DEPTH-2: per-VC almost-full threshold; 1..DEPTH.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 write  input  1  write request.
REQ-008 wr_vc  input  clog2(NUM_VC), min 1  target VC of write.
REQ-009 data_in  input  WIDTH  write flit.
REQ-010 read  input  1  read (pop) request.
REQ-011 rd_vc  input  clog2(NUM_VC), min 1  VC to read/pop.
REQ-012 data_out  output  WIDTH  head flit of VC rd_vc, combinational (first-word fall-through).
REQ-013 full  output  NUM_VC  bit v = VC v holds DEPTH entries.
REQ-014 empty  output  NUM_VC  bit v = VC v holds 0 entries.
REQ-015 afull  output  NUM_VC  bit v = count(v) >= AFULL_TH.
REQ-016 count  output  NUM_VC*(clog2(DEPTH)+1)  packed occupancy, VC v at slice [v*(clog2(DEPTH)+1) +: clog2(DEPTH)+1].

Function
REQ-017 Each VC SHALL be an independent circular buffer with write/read pointers of clog2(DEPTH)+1 bits; MSB is wrap flag.
REQ-018 full(v) SHALL assert when pointer LSBs match and wrap flags differ; empty(v) when pointers fully equal; both combinational from registered pointers.
REQ-019 Write SHALL be accepted iff write=1, wr_vc<NUM_VC and full(wr_vc)=0; accepted flit is stored and the write pointer advances on the same edge.
REQ-020 Read SHALL be accepted iff read=1, rd_vc<NUM_VC and empty(rd_vc)=0; the read pointer advances on that edge; data_out shows the next head after it.
REQ-021 Rejected writes/reads (full, empty, out-of-range VC) SHALL change no state.
REQ-022 Write to a full VC SHALL be rejected even if a read of the same VC occurs that cycle.
REQ-023 Read of an empty VC SHALL be rejected even if a write to the same VC occurs that cycle; no bypass; data appears next cycle.
REQ-024 Simultaneous accepted read and write on one VC SHALL leave count unchanged; on different VCs each count changes by one.
REQ-025 Pointer LSBs SHALL wrap DEPTH-1 -> 0, toggling the wrap flag.
REQ-026 data_out SHALL be don't-care while empty(rd_vc)=1.
REQ-027 count(v) SHALL equal write pointer minus read pointer modulo 2*DEPTH, range 0..DEPTH.

Reset
REQ-028 reset=0 SHALL immediately, asynchronously clear all pointers and wrap flags: empty=all ones, full=0, afull=0, count=0.
REQ-029 Storage array SHALL NOT be reset; release of reset SHALL be synchronous to clk.
REQ-030 Reset mid-traffic SHALL discard all contents; no request is accepted while reset=0.

Configuration
REQ-031 Macro VC_FIFO_ERR_EN defined: output err  1  sticky flag SHALL set on the edge after any rejected request to an existing VC (write to full or read of empty), cleared only by reset.
REQ-032 Macro undefined: err port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Defaults: write 16 flits 0x0000..0x000F to VC2 -> full=0100, count(2)=16, afull(2) from 14th write; 17th write ignored.
REQ-034 Drain VC2 with read, rd_vc=2 -> data_out 0x0000..0x000F in order, empty=1111 after 16th read, wraps pointers.
REQ-035 VC0 holds 3; simultaneous write VC0 0xAAAA and read VC0 -> data_out advances, count(0) stays 3; 0xAAAA read last.
REQ-036 VC1 empty; write+read VC1 same cycle -> read rejected, count(1)=1 next cycle, data_out=write value with rd_vc=1.
REQ-037 Assert reset=0 mid-cycle with VC3 at 5 entries -> outputs reset before next clk edge; empty=1111, count=0.
REQ-038 With VC_FIFO_ERR_EN: write to full VC0 -> err=1 next cycle, held until reset; without macro build elaborates with no err.
